// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port round-robin arbiter.
// Optional FIFO_ARB_STATS_EN support uses STALL_CNT_W from here.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    localparam int STALL_CNT_W = 16;

    // Never returns less than 1 so single-entry ranges still get a bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set req bit at or above rr_ptr,
// wrapping N-1 -> 0.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] rr_ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    function automatic logic [W-1:0] wrap(input logic [W-1:0] base, input int k);
        int j;
        j = int'(base) + k;
        if (j >= N) j -= N;
        return W'(j);
    endfunction

    // Scan from the far end so the closest candidate is written last.
    always_comb begin
        idx = '0;
        any = |req;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[wrap(rr_ptr, k)]) idx = wrap(rr_ptr, k);
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the async FIFO write port (write-clock domain).
// Define FIFO_ARB_STATS_EN to add the saturating stall_cnt output.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int NUM_REQ   = 4,
    parameter int BURST_MAX = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*WIDTH-1:0]    req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        wen,
    output logic [WIDTH-1:0]            wdata,
    input  logic                        is_full,
    output logic [clog2(NUM_REQ)-1:0]   owner,
    output logic                        busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0]      stall_cnt
`endif
);

    localparam int OW = clog2(NUM_REQ);
    localparam int BW = clog2(BURST_MAX);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_MAX - 1);

    arb_state_t    state;
    logic [OW-1:0] rr_ptr;
    logic [OW-1:0] pick_idx;
    logic [OW-1:0] nxt_ptr;
    logic          pick_any;
    logic [BW-1:0] beat;
    logic          done;

    rr_pick #(
        .N (NUM_REQ),
        .W (OW)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Outputs decode registered state only, so reset clears them at once.
    assign busy  = (state == ARB_BURST);
    assign wen   = busy & req[owner] & ~is_full;
    assign wdata = req_data[owner*WIDTH +: WIDTH];
    assign gnt   = wen ? (NUM_REQ'(1) << owner) : '0;

    assign done = (wen & (req_last[owner] | (beat == BEAT_LAST)))
                | (busy & ~req[owner]);

    assign nxt_ptr = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ARB_IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            beat   <= '0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        owner <= pick_idx;
                        beat  <= '0;
                        state <= ARB_BURST;
                    end
                end
                ARB_BURST: begin
                    if (done) begin
                        state  <= ARB_IDLE;
                        rr_ptr <= nxt_ptr;
                    end else if (wen) begin
                        beat <= beat + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (busy & req[owner] & is_full & (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed vector table,
// corner sequences, NUM_REQ=3 wrap case and randomized model comparison.
module tb_fifo_wr_arbiter;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int BM = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req, req_last, gnt;
    logic [N*W-1:0] req_data;
    logic           is_full, wen, busy;
    logic [W-1:0]   wdata;
    logic [1:0]     owner;

    logic [2:0]     req3, last3, gnt3;
    logic [3*W-1:0] data3;
    logic           full3, wen3, busy3;
    logic [W-1:0]   wdata3;
    logic [1:0]     owner3;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0]    stall_cnt, stall3;
`endif

    fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N), .BURST_MAX(BM)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .gnt      (gnt),
        .wen      (wen),
        .wdata    (wdata),
        .is_full  (is_full),
        .owner    (owner),
        .busy     (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(3), .BURST_MAX(BM)) u_dut3 (
        .clk      (clk),
        .rst      (rst),
        .req      (req3),
        .req_data (data3),
        .req_last (last3),
        .gnt      (gnt3),
        .wen      (wen3),
        .wdata    (wdata3),
        .is_full  (full3),
        .owner    (owner3),
        .busy     (busy3)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stall_cnt(stall3)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [W-1:0] dat(input int i);
        return 16'hA5A5 + 16'(16'h1111 * i);
    endfunction

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] last;
        logic       full;
        logic [3:0] gnt;
        logic       busy;
        logic [1:0] own;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] l, input logic f,
                                input logic [3:0] g, input logic b, input logic [1:0] o);
        vec_t v;
        v.req = r; v.last = l; v.full = f; v.gnt = g; v.busy = b; v.own = o;
        return v;
    endfunction

    vec_t tbl[24];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0; req_last = '0; is_full = 1'b0;
        req3 = '0; last3 = '0; full3 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Reference model: active flag, owner, words still allowed, next priority.
    bit         m_busy;
    int         m_owner, m_left, m_ptr, m_stall;
    logic       e_wen;
    logic [3:0] e_gnt;

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_left = 0; m_ptr = 0; m_stall = 0;
    endtask

    task automatic model_outputs();
        e_wen = m_busy && req[m_owner] && !is_full;
        e_gnt = e_wen ? 4'(1 << m_owner) : 4'h0;
    endtask

    task automatic model_step();
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                if (!m_busy && req[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_left  = BM;
                    m_busy  = 1;
                end
            end
        end else if (e_wen) begin
            m_left--;
            if (req_last[m_owner] || m_left == 0) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % N;
            end
        end else if (!req[m_owner]) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % N;
        end else if (m_stall < 65535) begin
            m_stall++;
        end
    endtask

    int         writes;
    int         seq[$];
    logic [3:0] last_gnt;

    initial begin
        for (int i = 0; i < N; i++) req_data[i*W +: W] = dat(i);
        for (int i = 0; i < 3; i++) data3[i*W +: W] = dat(i + 8);

        tbl[0]  = mk(4'h1, 4'h0, 0, 4'h0, 0, 0);
        tbl[1]  = mk(4'h1, 4'h0, 0, 4'h1, 1, 0);
        tbl[2]  = mk(4'h1, 4'h1, 0, 4'h1, 1, 0);
        tbl[3]  = mk(4'h4, 4'h0, 0, 4'h0, 0, 0);
        tbl[4]  = mk(4'h4, 4'h0, 0, 4'h4, 1, 2);
        tbl[5]  = mk(4'h4, 4'h4, 0, 4'h4, 1, 2);
        tbl[6]  = mk(4'h9, 4'h0, 0, 4'h0, 0, 2);
        tbl[7]  = mk(4'h9, 4'h0, 0, 4'h8, 1, 3);
        tbl[8]  = mk(4'h9, 4'h0, 1, 4'h0, 1, 3);
        tbl[9]  = mk(4'h1, 4'h0, 0, 4'h0, 1, 3);
        tbl[10] = mk(4'h3, 4'h0, 0, 4'h0, 0, 3);
        tbl[11] = mk(4'h3, 4'h0, 0, 4'h1, 1, 0);
        tbl[12] = mk(4'h2, 4'h0, 0, 4'h0, 1, 0);
        tbl[13] = mk(4'h2, 4'h0, 0, 4'h0, 0, 0);
        tbl[14] = mk(4'h2, 4'h0, 0, 4'h2, 1, 1);
        tbl[15] = mk(4'h2, 4'h0, 1, 4'h0, 1, 1);
        tbl[16] = mk(4'h2, 4'h0, 1, 4'h0, 1, 1);
        tbl[17] = mk(4'h2, 4'h0, 1, 4'h0, 1, 1);
        tbl[18] = mk(4'h2, 4'h0, 0, 4'h2, 1, 1);
        tbl[19] = mk(4'h2, 4'h0, 0, 4'h2, 1, 1);
        tbl[20] = mk(4'h2, 4'h0, 0, 4'h2, 1, 1);
        tbl[21] = mk(4'h2, 4'h0, 0, 4'h0, 0, 1);
        tbl[22] = mk(4'h0, 4'h0, 0, 4'h0, 1, 1);
        tbl[23] = mk(4'h0, 4'h0, 0, 4'h0, 0, 1);

        rst = 1'b1;
        req = '0; req_last = '0; is_full = 1'b0;
        req3 = '0; last3 = '0; full3 = 1'b0;
        @(negedge clk);
        chk("reset_wen", 32'(wen), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_owner", 32'(owner), 32'd0);
        do_reset();

        // Directed vector table.
        for (int i = 0; i < 24; i++) begin
            req = tbl[i].req; req_last = tbl[i].last; is_full = tbl[i].full;
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_wen", i), 32'(wen), 32'(|tbl[i].gnt));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_owner", i), 32'(owner), 32'(tbl[i].own));
            if (|tbl[i].gnt)
                chk($sformatf("tbl%0d_wdata", i), 32'(wdata), 32'(dat(int'(tbl[i].own))));
            next_cycle();
        end
`ifdef FIFO_ARB_STATS_EN
        chk("tbl_stall_cnt", 32'(stall_cnt), 32'd4);
`endif

        // Round-robin with all requesters held: 16 writes in 20 cycles.
        do_reset();
        req = 4'hF;
        writes = 0;
        seq.delete();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (wen) begin
                writes++;
                seq.push_back(int'(owner));
            end
            next_cycle();
        end
        chk("rr_writes", 32'(writes), 32'd16);
        for (int k = 0; k < seq.size() && k < 16; k++)
            chk($sformatf("rr_owner%0d", k), 32'(seq[k]), 32'(k / 4));
        next_cycle();
        chk("rr_wrap_busy", 32'(busy), 32'd1);
        chk("rr_wrap_owner", 32'(owner), 32'd0);

        // Reset in the middle of a burst clears outputs without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_wen", 32'(wen), 32'd0);
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);

        // NUM_REQ=3 wrap: owner 2 then 0.
        do_reset();
        req3 = 3'b100; last3 = 3'b100;
        @(negedge clk);
        chk("w3_idle0", 32'(busy3), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("w3_gnt2", 32'(gnt3), 32'h4);
        chk("w3_owner2", 32'(owner3), 32'd2);
        next_cycle();
        req3 = 3'b101; last3 = 3'b101;
        @(negedge clk);
        chk("w3_idle1", 32'(busy3), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("w3_gnt0", 32'(gnt3), 32'h1);
        chk("w3_owner0", 32'(owner3), 32'd0);
        chk("w3_wdata0", 32'(wdata3), 32'(dat(8)));
        next_cycle();
        req3 = '0; last3 = '0;

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        last_gnt = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(req[i] && !last_gnt[i] && $urandom_range(0, 9) != 0)) begin
                    req[i]            = ($urandom_range(0, 2) != 0);
                    req_last[i]       = ($urandom_range(0, 3) == 0);
                    req_data[i*W +: W] = 16'($urandom);
                end
            end
            is_full = ($urandom_range(0, 4) == 0);
            @(negedge clk);
            model_outputs();
            chk("rnd_gnt", 32'(gnt), 32'(e_gnt));
            chk("rnd_wen", 32'(wen), 32'(e_wen));
            chk("rnd_busy", 32'(busy), 32'(m_busy));
            chk("rnd_owner", 32'(owner), 32'(m_owner));
            if (e_wen)
                chk("rnd_wdata", 32'(wdata), 32'(req_data[m_owner*W +: W]));
`ifdef FIFO_ARB_STATS_EN
            chk("rnd_stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
            last_gnt = e_gnt;
            model_step();
            next_cycle();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
